cnn_inst_sched: RTL and testbench

CNN_INST_SCHED -- requirements
Module: cnn_inst_sched

---
 rtl/cnn_inst_sched_if.sv | 24 ++
 rtl/cnn_inst_sched.sv | 152 +++++++++++++++
 tb/tb_cnn_inst_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_inst_sched_if.sv
// Bus bundle for the CNN instruction scheduler: Avalon-MM register port plus
// the instruction/start/done handshake toward the CNN engine.
interface cnn_inst_sched_if #(
  parameter int INST_W = 32
);
  logic [1:0]        address;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [INST_W-1:0] cnn_inst;
  logic              cnn_start;
  logic              cnn_done;
  logic [31:0]       status;

  modport slave (
    input  address, write, writedata, cnn_done,
    output readdata, cnn_inst, cnn_start, status
  );

  modport master (
    output address, write, writedata, cnn_done,
    input  readdata, cnn_inst, cnn_start, status
  );
endinterface

// File: rtl/cnn_inst_sched.sv
// CNN instruction scheduler: Avalon-MM fed instruction FIFO issued one at a time
// to the CNN engine. Optional interrupt output enabled by CNN_INST_SCHED_IRQ_EN.
//
// state | meaning
// IDLE  | waiting for enable and a non-empty FIFO
// ISSUE | cnn_start high for this one cycle, cnn_inst holds the popped word
// BUSY  | engine running, waiting for cnn_done
module cnn_inst_sched #(
  parameter int FIFO_DEPTH = 8,
  parameter int INST_W     = 32
) (
  input logic clk,
  input logic reset,
  cnn_inst_sched_if.slave bus
`ifdef CNN_INST_SCHED_IRQ_EN
  ,
  output logic irq
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t            state;
  logic [INST_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              enable, overflow, irq_pending;
  logic [31:0]       done_cnt;

  logic inst_wr, ctrl_wr, flush, empty, full, pop, push_ok;

  assign inst_wr = bus.write && (bus.address == 2'd1);
  assign ctrl_wr = bus.write && (bus.address == 2'd2);
  assign flush   = ctrl_wr && bus.writedata[1];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = (state == IDLE) && enable && !empty && !flush;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = inst_wr && !flush && (!full || pop);

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push_ok && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push_ok)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= bus.writedata[INST_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      enable   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (ctrl_wr)
        enable <= bus.writedata[0];
      if (inst_wr && !flush && full && !pop)
        overflow <= 1'b1;
      else if (ctrl_wr && bus.writedata[2])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.cnn_inst  <= '0;
      bus.cnn_start <= 1'b0;
      done_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.cnn_start <= 1'b0;
          if (pop) begin
            bus.cnn_inst  <= mem[rd_ptr];
            bus.cnn_start <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.cnn_start <= 1'b0;
          state         <= BUSY;
        end
        BUSY: begin
          bus.cnn_start <= 1'b0;
          if (bus.cnn_done) begin
            done_cnt <= done_cnt + 32'd1;
            state    <= IDLE;
          end
        end
        default: begin
          bus.cnn_start <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef CNN_INST_SCHED_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq_pending <= 1'b0;
    else if ((state == BUSY) && bus.cnn_done && (count_nxt == '0))
      irq_pending <= 1'b1;
    else if (ctrl_wr && bus.writedata[3])
      irq_pending <= 1'b0;
  end

  assign irq = irq_pending;
`else
  assign irq_pending = 1'b0;
`endif

  assign bus.status = {16'h0000, 8'(count), 3'b000, irq_pending, overflow,
                       (state != IDLE), full, empty};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.readdata <= '0;
    else begin
      case (bus.address)
        2'd0:    bus.readdata <= bus.status;
        2'd3:    bus.readdata <= done_cnt;
        default: bus.readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_inst_sched.sv
// Scoreboard bench for cnn_inst_sched: expected issued instructions and register
// reads are queued by the stimulus and checked by independent monitors.
module tb_cnn_inst_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  cnn_inst_sched_if #(.INST_W(32)) bus ();

`ifdef CNN_INST_SCHED_IRQ_EN
  logic irq;
  localparam logic [31:0] IRQ_B = 32'h10;
`else
  localparam logic [31:0] IRQ_B = 32'h0;
`endif

  cnn_inst_sched #(.FIFO_DEPTH(8), .INST_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef CNN_INST_SCHED_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] exp_inst[$];
  logic [31:0] exp_rd[$];
  string       rd_name[$];
  logic        rd_strobe = 1'b0;
  logic        rd_q = 1'b0;
  logic        start_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_q <= rd_strobe;

  // Read monitor: readdata one cycle after the address was presented.
  always @(negedge clk) begin
    if (rd_q) begin
      if (exp_rd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got 0x%08h with nothing queued", bus.readdata);
      end else
        chk(rd_name.pop_front(), bus.readdata, exp_rd.pop_front());
    end
  end

  // Issue monitor: every start pulse must match the next queued instruction.
  always @(negedge clk) begin
    if (bus.cnn_start) begin
      if (exp_inst.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL start_unexpected: cnn_inst 0x%08h with nothing queued", bus.cnn_inst);
      end else begin
        chk("cnn_inst", bus.cnn_inst, exp_inst.pop_front());
        chk("start_width", {31'd0, start_prev}, 32'd0);
      end
    end
    start_prev <= bus.cnn_start;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address   = a;
    bus.write     = 1'b1;
    bus.writedata = d;
    tick();
    bus.write     = 1'b0;
    bus.address   = 2'd0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] e);
    bus.address = a;
    exp_rd.push_back(e);
    rd_name.push_back(name);
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    bus.address = 2'd0;
  endtask

  task automatic done_pulse();
    bus.cnn_done = 1'b1;
    tick();
    bus.cnn_done = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.cnn_start) return;
      tick();
    end
    checks++;
    failures++;
    $display("FAIL %s: no cnn_start within %0d cycles, got 0 expected 1", name, budget);
  endtask

  initial begin
    bus.address   = 2'd0;
    bus.write     = 1'b0;
    bus.writedata = 32'd0;
    bus.cnn_done  = 1'b0;
    tick(2);
    chk("status_in_reset", bus.status, 32'h1);
    reset = 1'b0;

    rd("rst_status", 2'd0, 32'h1);
    rd("rst_done_cnt", 2'd3, 32'h0);
    rd("rd_addr1_zero", 2'd1, 32'h0);
    rd("rd_addr2_zero", 2'd2, 32'h0);

    // Two instructions issued back to back around one completion.
    wr(2'd1, 32'h11);
    wr(2'd1, 32'h22);
    exp_inst.push_back(32'h11);
    exp_inst.push_back(32'h22);
    rd("two_queued", 2'd0, 32'h0000_0200);
    wr(2'd2, 32'h1);
    wait_start("start_0x11", 4);
    tick();
    done_pulse();
    wait_start("start_0x22", 4);
    tick();
    done_pulse();
    wr(2'd2, 32'h0);
    rd("done_cnt_2", 2'd3, 32'd2);
    rd("idle_empty", 2'd0, 32'h1 | IRQ_B);
`ifdef CNN_INST_SCHED_IRQ_EN
    chk("irq_set", {31'd0, irq}, 32'd1);
`endif
    wr(2'd2, 32'h8);
    rd("irq_cleared", 2'd0, 32'h1);
`ifdef CNN_INST_SCHED_IRQ_EN
    chk("irq_clear", {31'd0, irq}, 32'd0);
`endif

    // Nine pushes into an 8-deep FIFO while disabled.
    for (int i = 0; i < 9; i++) wr(2'd1, 32'h100 + i);
    rd("full_overflow", 2'd0, 32'h0000_080A);
    wr(2'd2, 32'h4);
    rd("overflow_clr", 2'd0, 32'h0000_0802);

    // Push lands on the same edge as the pop from a full FIFO.
    exp_inst.push_back(32'h100);
    wr(2'd2, 32'h1);
    wr(2'd1, 32'h555);
    wr(2'd2, 32'h0);
    rd("push_on_pop", 2'd0, 32'h0000_0806);
    done_pulse();
    rd("still_full", 2'd0, 32'h0000_0802);
    rd("done_cnt_3", 2'd3, 32'd3);

    // Flush during BUSY, enable kept high.
    wr(2'd2, 32'h2);
    rd("flushed", 2'd0, 32'h1);
    wr(2'd1, 32'h31);
    wr(2'd1, 32'h32);
    wr(2'd1, 32'h33);
    exp_inst.push_back(32'h31);
    wr(2'd2, 32'h1);
    wait_start("start_0x31", 4);
    tick();
    wr(2'd2, 32'h3);
    rd("flush_busy", 2'd0, 32'h5);
    done_pulse();
    rd("done_cnt_4", 2'd3, 32'd4);
    tick(5);
    rd("after_flush", 2'd0, 32'h1 | IRQ_B);
    wr(2'd2, 32'h8);
    rd("after_clear", 2'd0, 32'h1);

    // Reset while BUSY abandons the instruction.
    wr(2'd1, 32'h77);
    exp_inst.push_back(32'h77);
    wr(2'd2, 32'h1);
    wait_start("start_0x77", 4);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_reset_status", bus.status, 32'h1);
    reset = 1'b0;
    done_pulse();
    tick(4);
    rd("reset_done_cnt", 2'd3, 32'h0);
    rd("reset_status", 2'd0, 32'h1);
`ifdef CNN_INST_SCHED_IRQ_EN
    chk("irq_after_reset", {31'd0, irq}, 32'd0);
`endif

    tick(2);
    chk("inst_queue_drained", exp_inst.size(), 32'd0);
    chk("rd_queue_drained", exp_rd.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, got running expected finished");
    $fatal(1);
  end

endmodule
